chrono_run_controller: RTL
==========================

Name: chrono_run_controller

Overview:
- Control FSM for the start/stop chronometer with reset and lap.
- Takes two raw pushbuttons, Start/Stop and Lap/Reset, and synchronises, edge-detects and locks out each one.
- Sequences the external time counter and display latch through enable, clear, freeze and lap-capture strobes.
- Sits between the board pushbuttons and the counter/display datapath; it contains no time counter of its own.

Parameters:
- CLK_DIV, 25000, clk_ms cycles per 1 kHz lockout tick (25 MHz master clock).
- LOCKOUT_MS, 100, lockout ticks after an accepted press; further presses on that button are ignored during this window (8-bit, 1..255).

Ports:
- clk_ms  in  1  master clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- btn_startstop  in  1  raw Start/Stop button, asynchronous, 1 = pressed.
- btn_lapreset  in  1  raw Lap/Reset button, asynchronous, 1 = pressed.
- count_en  out  1  1 = external time counter advances.
- count_clr  out  1  one-cycle pulse; clears the external time counter.
- display_freeze  out  1  1 = display shows the latched lap value; 0 = display shows the live counter.
- lap_capture  out  1  one-cycle pulse; latches the live count into the lap register.
- run_state  out  2  FSM state: 0 IDLE, 1 RUNNING, 2 LAP, 3 STOPPED.
- lap_count  out  4  number of laps taken (see Optional Feature).

Behaviour:
- Reset, checked on the clock edge:
  - run_state = IDLE; count_en, count_clr, display_freeze, lap_capture and lap_count = 0.
  - Tick divider = 0; both lockouts armed; synchroniser flops = 0.
- Tick divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when the count equals CLK_DIV-1.
- Per-button front end (identical for both buttons):
  - 2-flop synchroniser, then a delayed copy for edge detection.
  - A rising edge while armed produces a one-cycle press pulse and disarms the button.
  - Disarm clears the lockout counter; the counter increments on each tick and re-arms the button when it reaches LOCKOUT_MS.
  - Effective lockout is between LOCKOUT_MS-1 and LOCKOUT_MS ms, because the first tick can be partial.
  - Holding a button never retriggers, since only rising edges are detected.
- Latency: outputs change on the 3rd clk_ms edge after the first edge at which the raw input is sampled high.
- FSM transitions (ss = Start/Stop press pulse, lr = Lap/Reset press pulse):
  - IDLE: ss -> RUNNING. lr -> stay in IDLE and pulse count_clr.
  - RUNNING: ss -> STOPPED. lr -> LAP and pulse lap_capture.
  - LAP: lr -> RUNNING (new live view, no capture). ss -> STOPPED.
  - STOPPED: ss -> RUNNING (resume, no clear). lr -> IDLE and pulse count_clr.
- Output decode, registered:
  - count_en = 1 in RUNNING and LAP.
  - display_freeze = 1 only in LAP.
  - count_clr and lap_capture are registered pulses, asserted in the same cycle as the run_state update.
- Simultaneous ss and lr in the same cycle: ss wins and lr is discarded. The lr button still enters lockout.
- Presses during lockout have no effect on the FSM.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - Pending pulses are dropped and lockouts are re-armed.
  - The external counter is cleared by the shared reset line, not by count_clr.

Optional Feature:
- Macro: CHRONO_LAP_COUNTER_EN.
- With the macro defined, lap_count:
  - increments on each RUNNING->LAP transition;
  - saturates at 15;
  - is cleared when count_clr pulses or on reset.
- Without the macro: lap_count is tied to 0 and no counter logic is built.

Test Plan (CLK_DIV=4, LOCKOUT_MS=3):
- Reset, then ss press -> on 3rd edge run_state=1, count_en=1, display_freeze=0.
- RUNNING, lr press -> run_state=2, lap_capture high exactly 1 cycle, display_freeze=1, count_en=1. Then lr again after lockout -> run_state=1, display_freeze=0, no capture pulse.
- RUNNING, ss -> run_state=3, count_en=0. Then lr -> run_state=0 with count_clr high 1 cycle. Separately, lr in IDLE -> count_clr pulse, state stays 0.
- Bounce: second ss rising edge 5 cycles after the first -> ignored. Rising edge 13+ cycles after the first -> accepted, state toggles.
- ss and lr rising in the same cycle from RUNNING -> run_state=3, no lap_capture. Reset asserted while in LAP -> next edge run_state=0, all outputs 0.
- With CHRONO_LAP_COUNTER_EN: 17 RUNNING->LAP cycles -> lap_count=15. STOPPED + lr -> lap_count=0. Without the macro -> lap_count always 0.

Source files
------------

// File: rtl/chrono_run_controller_if.sv
// Bundle between the chronometer control FSM and the board/datapath side.
// Ports: buttons in, counter/display strobes and status out of the slave.
interface chrono_run_controller_if;
  logic       btn_startstop;
  logic       btn_lapreset;
  logic       count_en;
  logic       count_clr;
  logic       display_freeze;
  logic       lap_capture;
  logic [1:0] run_state;
  logic [3:0] lap_count;

  modport master (
    output btn_startstop,
    output btn_lapreset,
    input  count_en,
    input  count_clr,
    input  display_freeze,
    input  lap_capture,
    input  run_state,
    input  lap_count
  );

  modport slave (
    input  btn_startstop,
    input  btn_lapreset,
    output count_en,
    output count_clr,
    output display_freeze,
    output lap_capture,
    output run_state,
    output lap_count
  );
endinterface

// File: rtl/chrono_run_controller.sv
// Start/stop/lap chronometer control FSM with button sync, edge and lockout.
// Ports: clk_ms, reset (sync, active-high), bus (slave): btn_startstop,
// btn_lapreset in; count_en, count_clr, display_freeze, lap_capture,
// run_state[1:0], lap_count[3:0] out.
// Optional: define CHRONO_LAP_COUNTER_EN to build the saturating lap counter.
module chrono_run_controller #(
  parameter int CLK_DIV    = 25000,
  parameter int LOCKOUT_MS = 100
) (
  input  logic                    clk_ms,
  input  logic                    reset,
  chrono_run_controller_if.slave  bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_MS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2,
    STOPPED = 2'd3
  } state_t;

  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk_ms) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Bit 0 = Start/Stop, bit 1 = Lap/Reset.
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      dly;
  logic [1:0]      armed;
  logic [1:0]      press;
  logic [1:0][7:0] lock_cnt;

  assign raw   = {bus.btn_lapreset, bus.btn_startstop};
  assign press = sync2 & ~dly & armed;

  always_ff @(posedge clk_ms) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      dly      <= '0;
      armed    <= '1;
      lock_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      dly   <= sync2;
      for (int i = 0; i < 2; i++) begin
        if (press[i]) begin
          armed[i]    <= 1'b0;
          lock_cnt[i] <= '0;
        end else if (!armed[i] && tick) begin
          lock_cnt[i] <= lock_cnt[i] + 8'd1;
          // Re-arm as the count reaches LOCKOUT_MS.
          if (lock_cnt[i] == LOCK_LAST) armed[i] <= 1'b1;
        end
      end
    end
  end

  logic   ss;
  logic   lr;
  state_t state;
  state_t state_nx;
  logic   clr_nx;
  logic   cap_nx;

  assign ss = press[0];
  assign lr = press[1];

  // Start/Stop is tested first everywhere, so it wins a same-cycle tie.
  always_comb begin
    state_nx = state;
    clr_nx   = 1'b0;
    cap_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss)      state_nx = RUNNING;
        else if (lr) clr_nx   = 1'b1;
      end
      RUNNING: begin
        if (ss) begin
          state_nx = STOPPED;
        end else if (lr) begin
          state_nx = LAP;
          cap_nx   = 1'b1;
        end
      end
      LAP: begin
        if (ss)      state_nx = STOPPED;
        else if (lr) state_nx = RUNNING;
      end
      STOPPED: begin
        if (ss) begin
          state_nx = RUNNING;
        end else if (lr) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic count_en;
  logic count_clr;
  logic display_freeze;
  logic lap_capture;

  always_ff @(posedge clk_ms) begin
    if (reset) begin
      state          <= IDLE;
      count_en       <= 1'b0;
      count_clr      <= 1'b0;
      display_freeze <= 1'b0;
      lap_capture    <= 1'b0;
    end else begin
      state          <= state_nx;
      count_en       <= (state_nx == RUNNING) || (state_nx == LAP);
      count_clr      <= clr_nx;
      display_freeze <= (state_nx == LAP);
      lap_capture    <= cap_nx;
    end
  end

  assign bus.run_state      = state;
  assign bus.count_en       = count_en;
  assign bus.count_clr      = count_clr;
  assign bus.display_freeze = display_freeze;
  assign bus.lap_capture    = lap_capture;

`ifdef CHRONO_LAP_COUNTER_EN
  logic [3:0] laps;
  logic       lap_inc;

  assign lap_inc = (state == RUNNING) && (state_nx == LAP);

  always_ff @(posedge clk_ms) begin
    if (reset)                         laps <= '0;
    else if (clr_nx)                   laps <= '0;
    else if (lap_inc && laps != 4'hF)  laps <= laps + 4'd1;
  end

  assign bus.lap_count = laps;
`else
  assign bus.lap_count = 4'd0;
`endif

endmodule
